// File: rtl/alu_datapath.sv
// Datapath slave of the sequence control FSM: register file, operand muxes,
// 2-bit-op ALU, registered result/flag stage and host preload/debug port.
module alu_datapath #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [14:0]      ctrl,
    input  logic             ld_en,
    input  logic [3:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] alu_out,
    output logic             mayor,
    output logic             bandera
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_AND  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

    alu_op_e          op;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;
    logic [3:0]       sel_dst;
    logic             w;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;

    logic [WIDTH-1:0] alu_out_q;
    logic             mayor_q;
    logic             bandera_q;

    assign op      = alu_op_e'(ctrl[14:13]);
    assign sel_a   = ctrl[12:9];
    assign sel_b   = ctrl[8:5];
    assign sel_dst = ctrl[4:1];
    assign w       = ctrl[0];

    assign opa = regs_q[sel_a];
    assign opb = regs_q[sel_b];

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = opa + opb;
            OP_SUB:  res = opa - opb;
            OP_AND:  res = opa & opb;
            OP_PASS: res = opa;
            default: res = '0;
        endcase
    end

    // Preload is applied after the ALU write so it wins on an address collision.
    always_comb begin
        regs_d = regs_q;
        if (w)
            regs_d[sel_dst] = res;
        if (ld_en)
            regs_d[ld_addr] = ld_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            alu_out_q <= '0;
            mayor_q   <= 1'b0;
            bandera_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            alu_out_q <= res;
            mayor_q   <= (opa > opb);
            bandera_q <= (res == '0);
        end
    end

    assign dbg_data = regs_q[dbg_addr];
    assign alu_out  = alu_out_q;
    assign mayor    = mayor_q;
    assign bandera  = bandera_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath: one task per scenario,
// expected values hand-computed for WIDTH=8.
`timescale 1ns/1ps
module tb_alu_datapath;

    logic        clk;
    logic        rst;
    logic [14:0] ctrl;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic [7:0]  alu_out;
    logic        mayor;
    logic        bandera;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_datapath #(.WIDTH(8), .NREG(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .alu_out  (alu_out),
        .mayor    (mayor),
        .bandera  (bandera)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [14:0] mk(input logic [1:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] d,
                                       input logic wr);
        return {op, a, b, d, wr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        ctrl = '0; ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (alu_out !== 8'd0) begin n_fail++; $display("FAIL reset_alu_out got=%0d exp=0", alu_out); end
        n_cmp++; if (mayor !== 1'b0) begin n_fail++; $display("FAIL reset_mayor got=%b exp=0", mayor); end
        n_cmp++; if (bandera !== 1'b0) begin n_fail++; $display("FAIL reset_bandera got=%b exp=0", bandera); end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0]; #1;
            n_cmp++; if (dbg_data !== 8'd0) begin n_fail++; $display("FAIL reset_reg%0d got=%0d exp=0", i, dbg_data); end
        end
    endtask

    task automatic test_add();
        preload(4'd1, 8'd5);
        preload(4'd2, 8'd3);
        ctrl = mk(2'b00, 4'd1, 4'd2, 4'd3, 1'b1);
        tick();
        ctrl = '0;
        n_cmp++; if (alu_out !== 8'd8) begin n_fail++; $display("FAIL add_alu_out got=%0d exp=8", alu_out); end
        n_cmp++; if (mayor !== 1'b1) begin n_fail++; $display("FAIL add_mayor got=%b exp=1", mayor); end
        n_cmp++; if (bandera !== 1'b0) begin n_fail++; $display("FAIL add_bandera got=%b exp=0", bandera); end
        dbg_addr = 4'd3; #1;
        n_cmp++; if (dbg_data !== 8'd8) begin n_fail++; $display("FAIL add_reg3 got=%0d exp=8", dbg_data); end
    endtask

    task automatic test_wrap();
        preload(4'd1, 8'd200);
        preload(4'd2, 8'd100);
        ctrl = mk(2'b00, 4'd1, 4'd2, 4'd4, 1'b1);
        tick();
        n_cmp++; if (alu_out !== 8'd44) begin n_fail++; $display("FAIL wrap_add_alu_out got=%0d exp=44", alu_out); end
        n_cmp++; if (mayor !== 1'b1) begin n_fail++; $display("FAIL wrap_add_mayor got=%b exp=1", mayor); end
        dbg_addr = 4'd4; #1;
        n_cmp++; if (dbg_data !== 8'd44) begin n_fail++; $display("FAIL wrap_reg4 got=%0d exp=44", dbg_data); end
        ctrl = mk(2'b01, 4'd2, 4'd1, 4'd0, 1'b0);
        tick();
        ctrl = '0;
        n_cmp++; if (alu_out !== 8'd156) begin n_fail++; $display("FAIL wrap_sub_alu_out got=%0d exp=156", alu_out); end
        n_cmp++; if (mayor !== 1'b0) begin n_fail++; $display("FAIL wrap_sub_mayor got=%b exp=0", mayor); end
        n_cmp++; if (bandera !== 1'b0) begin n_fail++; $display("FAIL wrap_sub_bandera got=%b exp=0", bandera); end
    endtask

    task automatic test_equal();
        preload(4'd5, 8'd7);
        preload(4'd6, 8'd7);
        ctrl = mk(2'b01, 4'd5, 4'd6, 4'd5, 1'b0);
        tick();
        n_cmp++; if (bandera !== 1'b1) begin n_fail++; $display("FAIL eq_bandera got=%b exp=1", bandera); end
        n_cmp++; if (mayor !== 1'b0) begin n_fail++; $display("FAIL eq_mayor got=%b exp=0", mayor); end
        dbg_addr = 4'd5; #1;
        n_cmp++; if (dbg_data !== 8'd7) begin n_fail++; $display("FAIL eq_nowrite_reg5 got=%0d exp=7", dbg_data); end
        ld_en = 1'b1; ld_addr = 4'd5; ld_data = 8'd9;
        tick();
        ld_en = 1'b0;
        n_cmp++; if (bandera !== 1'b1) begin n_fail++; $display("FAIL eq_lag_bandera got=%b exp=1", bandera); end
        tick();
        ctrl = '0;
        n_cmp++; if (alu_out !== 8'd2) begin n_fail++; $display("FAIL eq_swap_alu_out got=%0d exp=2", alu_out); end
        n_cmp++; if (bandera !== 1'b0) begin n_fail++; $display("FAIL eq_swap_bandera got=%b exp=0", bandera); end
        n_cmp++; if (mayor !== 1'b1) begin n_fail++; $display("FAIL eq_swap_mayor got=%b exp=1", mayor); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        preload(4'd1, 8'd4);
        ctrl = mk(2'b00, 4'd1, 4'd1, 4'd1, 1'b1);
        exp_v = 8'd4;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_v = exp_v * 8'd2;
            n_cmp++; if (alu_out !== exp_v) begin n_fail++; $display("FAIL rbw_alu_out_%0d got=%0d exp=%0d", k, alu_out, exp_v); end
            dbg_addr = 4'd1; #1;
            n_cmp++; if (dbg_data !== exp_v) begin n_fail++; $display("FAIL rbw_reg1_%0d got=%0d exp=%0d", k, dbg_data, exp_v); end
        end
        ctrl = '0;
    endtask

    task automatic test_logic_ops();
        preload(4'd8, 8'hF0);
        preload(4'd9, 8'h3C);
        ctrl = mk(2'b10, 4'd8, 4'd9, 4'd10, 1'b1);
        tick();
        n_cmp++; if (alu_out !== 8'h30) begin n_fail++; $display("FAIL and_alu_out got=%h exp=30", alu_out); end
        n_cmp++; if (mayor !== 1'b1) begin n_fail++; $display("FAIL and_mayor got=%b exp=1", mayor); end
        preload(4'd9, 8'h0F);
        ctrl = mk(2'b10, 4'd8, 4'd9, 4'd0, 1'b0);
        tick();
        n_cmp++; if (bandera !== 1'b1) begin n_fail++; $display("FAIL and_zero_bandera got=%b exp=1", bandera); end
        ctrl = mk(2'b11, 4'd9, 4'd8, 4'd11, 1'b1);
        tick();
        ctrl = '0;
        n_cmp++; if (alu_out !== 8'h0F) begin n_fail++; $display("FAIL pass_alu_out got=%h exp=0f", alu_out); end
        n_cmp++; if (mayor !== 1'b0) begin n_fail++; $display("FAIL pass_mayor got=%b exp=0", mayor); end
        dbg_addr = 4'd11; #1;
        n_cmp++; if (dbg_data !== 8'h0F) begin n_fail++; $display("FAIL pass_reg11 got=%h exp=0f", dbg_data); end
    endtask

    task automatic test_collision();
        preload(4'd7, 8'h11);
        ctrl = mk(2'b11, 4'd7, 4'd0, 4'd3, 1'b1);
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 8'hAA;
        tick();
        n_cmp++; if (alu_out !== 8'h11) begin n_fail++; $display("FAIL col_alu_out got=%h exp=11", alu_out); end
        n_cmp++; if (mayor !== 1'b1) begin n_fail++; $display("FAIL col_mayor got=%b exp=1", mayor); end
        dbg_addr = 4'd3; #1;
        n_cmp++; if (dbg_data !== 8'hAA) begin n_fail++; $display("FAIL col_same_reg3 got=%h exp=aa", dbg_data); end
        ld_addr = 4'd4;
        tick();
        ld_en = 1'b0; ctrl = '0;
        dbg_addr = 4'd3; #1;
        n_cmp++; if (dbg_data !== 8'h11) begin n_fail++; $display("FAIL col_diff_reg3 got=%h exp=11", dbg_data); end
        dbg_addr = 4'd4; #1;
        n_cmp++; if (dbg_data !== 8'hAA) begin n_fail++; $display("FAIL col_diff_reg4 got=%h exp=aa", dbg_data); end
    endtask

    task automatic test_idle();
        preload(4'd0, 8'h80);
        ctrl = '0;
        tick();
        n_cmp++; if (alu_out !== 8'h00) begin n_fail++; $display("FAIL idle80_alu_out got=%h exp=00", alu_out); end
        n_cmp++; if (bandera !== 1'b1) begin n_fail++; $display("FAIL idle80_bandera got=%b exp=1", bandera); end
        n_cmp++; if (mayor !== 1'b0) begin n_fail++; $display("FAIL idle80_mayor got=%b exp=0", mayor); end
        preload(4'd0, 8'h81);
        tick();
        n_cmp++; if (alu_out !== 8'h02) begin n_fail++; $display("FAIL idle81_alu_out got=%h exp=02", alu_out); end
        n_cmp++; if (bandera !== 1'b0) begin n_fail++; $display("FAIL idle81_bandera got=%b exp=0", bandera); end
        dbg_addr = 4'd0; #1;
        n_cmp++; if (dbg_data !== 8'h81) begin n_fail++; $display("FAIL idle_reg0 got=%h exp=81", dbg_data); end
    endtask

    task automatic test_async_reset();
        // r1=32, r2=100 left by earlier scenarios
        ctrl = mk(2'b00, 4'd1, 4'd2, 4'd5, 1'b1);
        tick();
        n_cmp++; if (alu_out !== 8'd132) begin n_fail++; $display("FAIL prerst_alu_out got=%0d exp=132", alu_out); end
        ctrl = mk(2'b11, 4'd1, 4'd2, 4'd6, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (alu_out !== 8'd0) begin n_fail++; $display("FAIL arst_alu_out got=%0d exp=0", alu_out); end
        n_cmp++; if (mayor !== 1'b0) begin n_fail++; $display("FAIL arst_mayor got=%b exp=0", mayor); end
        n_cmp++; if (bandera !== 1'b0) begin n_fail++; $display("FAIL arst_bandera got=%b exp=0", bandera); end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0]; #1;
            n_cmp++; if (dbg_data !== 8'd0) begin n_fail++; $display("FAIL arst_reg%0d got=%0d exp=0", i, dbg_data); end
        end
        tick();
        dbg_addr = 4'd6; #1;
        n_cmp++; if (dbg_data !== 8'd0) begin n_fail++; $display("FAIL arst_held_reg6 got=%0d exp=0", dbg_data); end
        n_cmp++; if (alu_out !== 8'd0) begin n_fail++; $display("FAIL arst_held_alu_out got=%0d exp=0", alu_out); end
        rst = 1'b0;
        preload(4'd1, 8'd6);
        n_cmp++; if (bandera !== 1'b1) begin n_fail++; $display("FAIL post_bandera got=%b exp=1", bandera); end
        dbg_addr = 4'd1; #1;
        n_cmp++; if (dbg_data !== 8'd6) begin n_fail++; $display("FAIL post_reg1 got=%0d exp=6", dbg_data); end
        ctrl = mk(2'b00, 4'd1, 4'd1, 4'd2, 1'b1);
        tick();
        ctrl = '0;
        n_cmp++; if (alu_out !== 8'd12) begin n_fail++; $display("FAIL post_alu_out got=%0d exp=12", alu_out); end
        dbg_addr = 4'd2; #1;
        n_cmp++; if (dbg_data !== 8'd12) begin n_fail++; $display("FAIL post_reg2 got=%0d exp=12", dbg_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ctrl = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        #25;
        test_reset();
        rst = 1'b0;
        test_add();
        test_wrap();
        test_equal();
        test_back_to_back();
        test_logic_ops();
        test_collision();
        test_idle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_datapath.md
Name: alu_datapath

Overview:
- Datapath slave of the sequence control FSM: consumes its 15-bit control word, returns status flags `mayor` and `bandera`.
- Contains a 16-entry register file, two 4-bit-select operand muxes, a 2-bit-op ALU, a registered flag stage, and a host preload/debug port.
- Sits beside the control FSM in the top level; the FSM's o_signal drives ctrl directly.

Parameters:
WIDTH, 8, data width of registers, operands, ALU
NREG, 16, register-file depth; fixed by the 4-bit select fields

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
ctrl  in  15  control word: [14:13] alu_op, [12:9] sel_a, [8:5] sel_b, [4:1] sel_dst, [0] w
ld_en  in  1  host preload strobe
ld_addr  in  4  host preload address
ld_data  in  WIDTH  host preload data
dbg_addr  in  4  debug read address
dbg_data  out  WIDTH  combinational read of reg[dbg_addr]
alu_out  out  WIDTH  registered ALU result
mayor  out  1  registered flag: A > B, unsigned
bandera  out  1  registered flag: ALU result == 0

Behaviour:
- Reset (async, rst=1):
  - all 16 registers clear to 0
  - alu_out=0, mayor=0, bandera=0
  - held while rst=1
  - reset mid-operation discards any pending write that cycle
- Operand muxes (combinational): A = reg[sel_a], B = reg[sel_b]. sel_a == sel_b is legal.
- ALU (combinational, result truncated to WIDTH):
  - 00 ADD: A+B, carry discarded
  - 01 SUB: A-B, two's-complement wrap
  - 10 AND: A&B
  - 11 PASS: A
- Flag/result stage, updated every rising edge unconditionally, independent of w:
  - alu_out <= R
  - mayor <= (A > B) unsigned
  - bandera <= (R == 0)
  - Flags reflect the ctrl value present one cycle earlier; latency 1 cycle.
  - The FSM holds the same ctrl for two states before branching, so the sampled flag is valid.
- Register write on rising edge:
  - w=1 → reg[sel_dst] <= R, using the pre-edge A/B.
  - Read-before-write: a write to sel_a/sel_b takes effect for operands on the next cycle only.
  - w=0 → no register change.
- Host preload on rising edge: ld_en=1 → reg[ld_addr] <= ld_data.
- Simultaneous ld_en and w:
  - different addresses → both writes occur
  - same address → preload wins, ALU write dropped
  - flags still update from the ALU
- ctrl all-zero (FSM idle/halt states): A=B=reg[0], ADD, no write. Flags continue updating: mayor=0; bandera=1 iff 2*reg[0] mod 2^WIDTH == 0.
- dbg_data reflects register contents after the most recent edge, purely combinational, no side effects.
- No X propagation: every code of every ctrl field is defined.

Test Plan:
- Preload r1=5, r2=3; ctrl = op 00, sel_a=1, sel_b=2, dst=3, w=1 → after 1 edge: reg3=8, alu_out=8, mayor=1, bandera=0; dbg_addr=3 reads 8.
- Preload r1=200, r2=100; ADD to dst 4, WIDTH=8 → reg4=44 (wrap), mayor=1. Then SUB with sel_a=2, sel_b=1 → alu_out=156, mayor=0.
- Preload r5=7, r6=7; SUB, w=0 → bandera=1, mayor=0, reg file unchanged. Swap to r5=9 via ld_en → next cycle bandera=0, mayor=1.
- Read-before-write: r1=4; ctrl ADD sel_a=1, sel_b=1, dst=1, w=1 for 3 edges → reg1 sequence 8, 16, 32; alu_out lags by matching value each edge.
- Collision: ld_en=1, ld_addr=3, ld_data=0xAA, same cycle as w=1, dst=3, R=0x11 → reg3=0xAA. Repeat with ld_addr=4 → reg3=0x11, reg4=0xAA.
- Assert rst asynchronously mid-sequence (between edges, with w=1 pending) → outputs drop to 0 immediately, all registers read 0 via dbg, no write lands. After release, the first edge resumes normal updates.
